pipe_hazard_ctrl: RTL and testbench

Central sequencing controller for the 5-stage pipeline (IF, ID, EXE, MEM, WB).
- Generates the PC write enable, the IF/ID enable, a common enable for the downstream pipeline registers, and per-stage flush (bubble) controls.
- Resolves load-use hazards, taken branches resolved in MEM, jumps decoded in ID, and ALU exceptions raised in EXE.
- Adds a RUN/HALT/STEP debug state machine and saturating hazard event counters.
- Sits beside the datapath at top level and drives the enables of PC, REG_IF_ID, REG_ID_EXE, REG_EXE_MEM and REG_MEM_WB.

---
 rtl/pipe_hazard_ctrl_if.sv | 57 +++++
 rtl/pipe_hazard_ctrl.sv | 110 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller signal bundle: datapath hazard/debug inputs and the pipeline enables/flushes.
// Breakpoint signals exist only when PIPE_BREAKPOINT_EN is defined.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
`ifdef PIPE_BREAKPOINT_EN
    , parameter int ADDR_W = 8
`endif
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic [4:0]       exe_rt;
    logic             exe_mem_read;
    logic             id_jump;
    logic             mem_branch_taken;
    logic             exe_exception;
    logic             dbg_halt;
    logic             dbg_run;
    logic             dbg_step;
    logic             cnt_clr;
    logic             pc_en;
    logic             if_id_en;
    logic             pipe_en;
    logic             if_id_flush;
    logic             id_exe_flush;
    logic             exe_mem_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
`ifdef PIPE_BREAKPOINT_EN
    logic [ADDR_W-1:0] pc_current;
    logic [ADDR_W-1:0] bp_addr;
    logic              bp_en;
`endif

    // Controller side.
    modport master (
`ifdef PIPE_BREAKPOINT_EN
        input  pc_current, bp_addr, bp_en,
`endif
        input  id_rs, id_rt, id_uses_rt, exe_rt, exe_mem_read, id_jump,
               mem_branch_taken, exe_exception, dbg_halt, dbg_run, dbg_step, cnt_clr,
        output pc_en, if_id_en, pipe_en, if_id_flush, id_exe_flush, exe_mem_flush,
               halted, stall_cnt, flush_cnt
    );

    // Datapath / debugger side.
    modport slave (
`ifdef PIPE_BREAKPOINT_EN
        output pc_current, bp_addr, bp_en,
`endif
        output id_rs, id_rt, id_uses_rt, exe_rt, exe_mem_read, id_jump,
               mem_branch_taken, exe_exception, dbg_halt, dbg_run, dbg_step, cnt_clr,
        input  pc_en, if_id_en, pipe_en, if_id_flush, id_exe_flush, exe_mem_flush,
               halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencer: enables/flushes, load-use/branch/jump/exception handling,
// RUN/HALT/STEP debug FSM and saturating event counters. Optional breakpoint: PIPE_BREAKPOINT_EN.
module pipe_hazard_ctrl #(
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 8
) (
    input logic                CLK,
    input logic                RESET,
    pipe_hazard_ctrl_if.master hz
);
    typedef enum logic [1:0] {S_RUN = 2'd0, S_HALT = 2'd1, S_STEP = 2'd2} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             act, load_use, bp_hit, stall_inc, flush_inc;
    logic             pc_en, if_id_en, pipe_en, if_id_flush, id_exe_flush, exe_mem_flush, halted;

    if (ADDR_W < 1) begin : g_addr_w_chk
        $error("ADDR_W must be at least 1");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign act      = (state_q == S_RUN) || (state_q == S_STEP);
    assign load_use = hz.exe_mem_read && (hz.exe_rt != 5'd0) &&
                      ((hz.exe_rt == hz.id_rs) || (hz.id_uses_rt && (hz.exe_rt == hz.id_rt)));
`ifdef PIPE_BREAKPOINT_EN
    // Only RUN honours the breakpoint so a STEP can move past it.
    assign bp_hit = (state_q == S_RUN) && hz.bp_en && (hz.pc_current == hz.bp_addr);
`else
    assign bp_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        pipe_en       = 1'b0;
        if_id_flush   = 1'b0;
        id_exe_flush  = 1'b0;
        exe_mem_flush = 1'b0;
        halted        = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        if (act) begin
            if (hz.mem_branch_taken) begin
                {pc_en, if_id_en, pipe_en} = 3'b111;
                {if_id_flush, id_exe_flush, exe_mem_flush} = 3'b111;
                flush_inc = 1'b1;
            end else if (bp_hit) begin
                state_d = S_HALT;
            end else if (hz.exe_exception) begin
                pipe_en       = 1'b1;
                exe_mem_flush = 1'b1;
                flush_inc     = 1'b1;
                state_d       = S_HALT;
            end else if (load_use) begin
                pipe_en      = 1'b1;
                id_exe_flush = 1'b1;
                stall_inc    = 1'b1;
            end else if (hz.id_jump) begin
                {pc_en, if_id_en, pipe_en} = 3'b111;
                if_id_flush = 1'b1;
                flush_inc   = 1'b1;
            end else begin
                {pc_en, if_id_en, pipe_en} = 3'b111;
            end
            if ((state_q == S_STEP) || hz.dbg_halt) begin
                state_d = S_HALT;
            end
        end else begin
            halted = 1'b1;
            if (hz.dbg_run) begin
                state_d = S_RUN;
            end else if (hz.dbg_step) begin
                state_d = S_STEP;
            end
        end
    end

    // Clear wins over a same-cycle increment.
    assign stall_cnt_d = hz.cnt_clr ? '0 : (stall_inc ? sat_inc(stall_cnt_q) : stall_cnt_q);
    assign flush_cnt_d = hz.cnt_clr ? '0 : (flush_inc ? sat_inc(flush_cnt_q) : flush_cnt_q);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Reset forces every control output low without waiting for a clock.
    assign hz.pc_en         = pc_en & ~RESET;
    assign hz.if_id_en      = if_id_en & ~RESET;
    assign hz.pipe_en       = pipe_en & ~RESET;
    assign hz.if_id_flush   = if_id_flush & ~RESET;
    assign hz.id_exe_flush  = id_exe_flush & ~RESET;
    assign hz.exe_mem_flush = exe_mem_flush & ~RESET;
    assign hz.halted        = halted & ~RESET;
    assign hz.stall_cnt     = stall_cnt_q;
    assign hz.flush_cnt     = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against a spec-level reference model.
// Small counter width so saturation is reachable; covers PIPE_BREAKPOINT_EN when defined.
module tb_pipe_hazard_ctrl;
    localparam int CNT_W  = 4;
    localparam int ADDR_W = 8;
    localparam int SAT    = (1 << CNT_W) - 1;

    logic CLK;
    logic RESET;

`ifdef PIPE_BREAKPOINT_EN
    pipe_hazard_ctrl_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) hz ();
`else
    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();
`endif

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .hz    (hz.master)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: "halted" and "single step in progress" flags plus integer counters.
    bit       m_halted, m_stepping;
    int       m_stall, m_flush;
    bit [6:0] exp_ctl;
    bit       m_inc_s, m_inc_f, m_nxt_h, m_nxt_s;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_idle();
        hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_uses_rt = 1'b0; hz.exe_rt = 5'd0;
        hz.exe_mem_read = 1'b0; hz.id_jump = 1'b0; hz.mem_branch_taken = 1'b0;
        hz.exe_exception = 1'b0; hz.dbg_halt = 1'b0; hz.dbg_run = 1'b0;
        hz.dbg_step = 1'b0; hz.cnt_clr = 1'b0;
`ifdef PIPE_BREAKPOINT_EN
        hz.pc_current = '0; hz.bp_addr = 8'hff; hz.bp_en = 1'b0;
`endif
    endtask

    // Expected outputs as {pc_en, if_id_en, pipe_en, if_id_flush, id_exe_flush, exe_mem_flush, halted}.
    task automatic model_eval();
        bit lu, bp;
        lu = hz.exe_mem_read && hz.exe_rt != 0 &&
             (hz.exe_rt == hz.id_rs || (hz.id_uses_rt && hz.exe_rt == hz.id_rt));
        bp = 1'b0;
`ifdef PIPE_BREAKPOINT_EN
        bp = !m_halted && !m_stepping && hz.bp_en && hz.pc_current == hz.bp_addr;
`endif
        exp_ctl = 7'b0; m_inc_s = 0; m_inc_f = 0; m_nxt_h = m_halted; m_nxt_s = 0;
        if (m_halted) begin
            exp_ctl = 7'b000_000_1;
            if (hz.dbg_run) m_nxt_h = 0;
            else if (hz.dbg_step) begin m_nxt_h = 0; m_nxt_s = 1; end
        end else begin
            if (hz.mem_branch_taken) begin exp_ctl = 7'b111_111_0; m_inc_f = 1; end
            else if (bp) m_nxt_h = 1;
            else if (hz.exe_exception) begin exp_ctl = 7'b001_001_0; m_inc_f = 1; m_nxt_h = 1; end
            else if (lu) begin exp_ctl = 7'b001_010_0; m_inc_s = 1; end
            else if (hz.id_jump) begin exp_ctl = 7'b111_100_0; m_inc_f = 1; end
            else exp_ctl = 7'b111_000_0;
            if (m_stepping || hz.dbg_halt) m_nxt_h = 1;
        end
    endtask

    task automatic model_commit();
        if (hz.cnt_clr) begin
            m_stall = 0; m_flush = 0;
        end else begin
            if (m_inc_s && m_stall < SAT) m_stall++;
            if (m_inc_f && m_flush < SAT) m_flush++;
        end
        m_halted = m_nxt_h; m_stepping = m_nxt_s;
    endtask

    // Inputs are set just after a rising edge; outputs are checked on the falling edge.
    task automatic run_cycle();
        @(negedge CLK);
        model_eval();
        check_val("ctl", {hz.pc_en, hz.if_id_en, hz.pipe_en, hz.if_id_flush,
                          hz.id_exe_flush, hz.exe_mem_flush, hz.halted}, exp_ctl);
        check_val("stall_cnt", hz.stall_cnt, m_stall);
        check_val("flush_cnt", hz.flush_cnt, m_flush);
        @(posedge CLK);
        model_commit();
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        #1;
        check_val("rst_ctl", {hz.pc_en, hz.if_id_en, hz.pipe_en, hz.if_id_flush,
                              hz.id_exe_flush, hz.exe_mem_flush, hz.halted}, 0);
        check_val("rst_cnt", {hz.stall_cnt, hz.flush_cnt}, 0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        m_halted = 0; m_stepping = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic set_load_use();
        hz.exe_mem_read = 1'b1; hz.exe_rt = 5'd5; hz.id_rs = 5'd5;
    endtask

    initial begin
        RESET = 1'b0;
        set_idle();
        #2;
        do_reset();

        run_cycle();
        run_cycle();

        set_load_use();
        run_cycle();
        check_val("stall_one", hz.stall_cnt, 1);
        hz.exe_rt = 5'd0;
        run_cycle();
        check_val("rt0_nostall", hz.stall_cnt, 1);
        set_idle();
        hz.exe_mem_read = 1'b1; hz.exe_rt = 5'd7; hz.id_rt = 5'd7; hz.id_uses_rt = 1'b1;
        run_cycle();
        set_idle();

        set_load_use();
        hz.mem_branch_taken = 1'b1; hz.exe_exception = 1'b1; hz.id_jump = 1'b1;
        run_cycle();
        check_val("br_run", hz.halted, 0);
        set_idle();

        hz.exe_exception = 1'b1;
        run_cycle();
        set_idle();
        run_cycle();
        run_cycle();
        hz.dbg_step = 1'b1;
        run_cycle();
        hz.dbg_step = 1'b0;
        run_cycle();
        run_cycle();
        hz.dbg_run = 1'b1; hz.dbg_step = 1'b1;
        run_cycle();
        set_idle();
        run_cycle();

        hz.dbg_halt = 1'b1; hz.id_jump = 1'b1;
        run_cycle();
        set_idle();
        hz.dbg_step = 1'b1; set_load_use();
        run_cycle();
        hz.dbg_step = 1'b0; hz.dbg_halt = 1'b1; hz.dbg_run = 1'b1;
        run_cycle();
        set_idle();
        run_cycle();
        hz.dbg_run = 1'b1;
        run_cycle();
        set_idle();

        set_load_use();
        for (int i = 0; i < 18; i++) run_cycle();
        check_val("stall_sat", hz.stall_cnt, SAT);
        hz.cnt_clr = 1'b1;
        run_cycle();
        check_val("clr_wins", hz.stall_cnt, 0);
        set_idle();
        hz.id_jump = 1'b1;
        for (int i = 0; i < 17; i++) run_cycle();
        check_val("flush_sat", hz.flush_cnt, SAT);
        set_idle();

`ifdef PIPE_BREAKPOINT_EN
        hz.bp_en = 1'b1; hz.bp_addr = 8'h10; hz.pc_current = 8'h10;
        run_cycle();
        run_cycle();
        hz.dbg_step = 1'b1;
        run_cycle();
        hz.dbg_step = 1'b0;
        run_cycle();
        run_cycle();
        hz.mem_branch_taken = 1'b1; hz.dbg_run = 1'b1;
        run_cycle();
        run_cycle();
        set_idle();
        hz.dbg_run = 1'b1;
        run_cycle();
        set_idle();
`endif

        set_load_use();
        run_cycle();
        do_reset();
        set_idle();
        run_cycle();

        for (int i = 0; i < 800; i++) begin
            hz.id_rs            = 5'($urandom_range(0, 3));
            hz.id_rt            = 5'($urandom_range(0, 3));
            hz.id_uses_rt       = 1'($urandom_range(0, 1));
            hz.exe_rt           = 5'($urandom_range(0, 3));
            hz.exe_mem_read     = ($urandom_range(0, 9) < 4);
            hz.id_jump          = ($urandom_range(0, 9) < 2);
            hz.mem_branch_taken = ($urandom_range(0, 9) < 1);
            hz.exe_exception    = ($urandom_range(0, 19) < 1);
            hz.dbg_halt         = ($urandom_range(0, 19) < 1);
            hz.dbg_run          = ($urandom_range(0, 9) < 2);
            hz.dbg_step         = ($urandom_range(0, 9) < 2);
            hz.cnt_clr          = ($urandom_range(0, 39) < 1);
`ifdef PIPE_BREAKPOINT_EN
            hz.bp_en            = ($urandom_range(0, 9) < 3);
            hz.bp_addr          = 8'($urandom_range(0, 3));
            hz.pc_current       = 8'($urandom_range(0, 3));
`endif
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                run_cycle();
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
